// File: rtl/sar_adc.sv
// Behavioural SAR ADC: converts real A_in into an NBITS code, one bit per clock, MSB first.
// Latency: start sampled at edge k -> valid pulses in the cycle after edge k+NBITS; busy spans NBITS cycles.
// Backpressure: none; start is ignored (never queued) while a conversion is in progress.
module sar_adc #(
  parameter int  NBITS = 8,
  parameter real VREF  = 3.3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  real              A_in,
  output logic             busy,
  output logic             valid,
  output logic [NBITS-1:0] O_data,
  output logic [NBITS-1:0] O_trial
);

  localparam int               IDXW       = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam real              FULL_SCALE = real'(2 ** NBITS);
  localparam logic [IDXW-1:0]  IDX_MSB    = IDXW'(NBITS - 1);
  localparam logic [NBITS-1:0] MSB_ONE    = NBITS'(1) << (NBITS - 1);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t           state_q, state_d;
  real              held_q, held_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             busy_d, valid_d;
  logic [NBITS-1:0] data_d, trial_d;
  logic [NBITS-1:0] code_res;
  real              thr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      held_q  <= 0.0;
      idx_q   <= '0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      O_data  <= '0;
      O_trial <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      idx_q   <= idx_d;
      busy    <= busy_d;
      valid   <= valid_d;
      O_data  <= data_d;
      O_trial <= trial_d;
    end
  end

  always_comb begin
    // Comparator: the trial bit survives only if the held sample reaches the trial level.
    thr      = real'(O_trial) * VREF / FULL_SCALE;
    code_res = O_trial;
    if (held_q < thr) code_res[idx_q] = 1'b0;

    state_d = state_q;
    held_d  = held_q;
    idx_d   = idx_q;
    busy_d  = busy;
    valid_d = 1'b0;
    data_d  = O_data;
    trial_d = O_trial;

    case (state_q)
      IDLE: begin
        if (start) begin
          held_d  = A_in;
          idx_d   = IDX_MSB;
          trial_d = MSB_ONE;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (idx_q == '0) begin
          data_d  = code_res;
          trial_d = code_res;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          trial_d                 = code_res;
          trial_d[idx_q - 1'b1]   = 1'b1;
          idx_d                   = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sar_adc.sv
// Scoreboard bench for sar_adc: expected codes are queued at stimulus time and popped on each valid pulse.
module tb_sar_adc;

  localparam int  NBITS = 8;
  localparam real VREF  = 3.3;
  localparam int  NCODE = 1 << NBITS;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  real              a_in = 0.0;
  logic             busy, valid;
  logic [NBITS-1:0] o_data, o_trial;

  int n_cmp = 0;
  int n_err = 0;
  int valid_cnt = 0;
  int cyc = 0;
  int sb[$];
  int vcyc[$];

  sar_adc #(.NBITS(NBITS), .VREF(VREF)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A_in    (a_in),
    .busy    (busy),
    .valid   (valid),
    .O_data  (o_data),
    .O_trial (o_trial)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, longint got, longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
    end
  endfunction

  // Reference: the largest code whose level V(c) = c*VREF/2**NBITS the input reaches, 0 if none.
  function automatic int ref_code(real a);
    int c = 0;
    for (int k = 1; k < NCODE; k++)
      if (a >= real'(k) * VREF / real'(NCODE)) c = k;
    return c;
  endfunction

  function automatic real dac(int code);
    return real'(code) * VREF / real'(NCODE);
  endfunction

  function automatic real rand_volt();
    return real'($urandom_range(0, 4500)) / 1000.0 - 0.5;
  endfunction

  // Monitor: every valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      valid_cnt++;
      vcyc.push_back(cyc);
      check("sb_nonempty_at_valid", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) check("o_data", o_data, sb.pop_front());
      check("busy_at_valid", busy, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_conv(real a, int exp);
    a_in  = a;
    start = 1'b1;
    sb.push_back(exp);
    tick();
    start = 1'b0;
    repeat (NBITS) tick();
    tick();
  endtask

  initial begin
    int code, bcnt, cnt0;
    int trial_exp;

    // Reset state
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_trial", o_trial, 0);
    rst_n = 1'b1;
    tick();

    // Mid-scale conversion with trial sequence and busy window
    code  = ref_code(1.65);
    a_in  = 1.65;
    start = 1'b1;
    sb.push_back(code);
    bcnt  = 0;
    for (int j = 0; j < NBITS; j++) begin
      tick();
      start = 1'b0;
      trial_exp = (code & ~((1 << (NBITS - j)) - 1)) | (1 << (NBITS - 1 - j));
      check($sformatf("trial_step%0d", j), o_trial, trial_exp);
      if (busy) bcnt++;
      check("no_early_valid", valid, 0);
    end
    tick();
    check("busy_cycles", bcnt, NBITS);
    check("valid_after_n", valid, 1);
    check("trial_final", o_trial, code);
    check("data_mid", o_data, 8'h80);
    tick();
    check("valid_one_cycle", valid, 0);

    // Fixed points including saturation
    do_conv(1.0, 8'h4D);
    do_conv(0.0, 8'h00);
    do_conv(3.3, 8'hFF);
    do_conv(-0.5, 8'h00);
    do_conv(5.0, 8'hFF);

    // Input change and extra starts during conversion
    cnt0  = valid_cnt;
    a_in  = 2.0;
    start = 1'b1;
    sb.push_back(ref_code(2.0));
    tick();
    start = 1'b0;
    repeat (2) tick();
    a_in  = 0.2;
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    repeat (4) tick();
    check("held_data", o_data, 8'h9B);
    check("busy_no_restart", busy, 0);
    repeat (3) tick();
    check("single_valid", valid_cnt - cnt0, 1);

    // Asynchronous reset mid-conversion
    cnt0  = valid_cnt;
    a_in  = 2.5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", valid, 0);
    check("arst_o_data", o_data, 0);
    check("arst_o_trial", o_trial, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (NBITS + 2) tick();
    check("arst_no_valid", valid_cnt - cnt0, 0);
    check("arst_idle", busy, 0);
    do_conv(1.65, 8'h80);

    // Randomised conversions against the reference model
    for (int n = 0; n < 40; n++) begin
      real a;
      a = rand_volt();
      do_conv(a, ref_code(a));
    end

    // DAC loopback over every code
    for (int c = 0; c < NCODE; c++) do_conv(dac(c), c);

    // start held high: back-to-back conversions
    vcyc.delete();
    a_in  = rand_volt();
    sb.push_back(ref_code(a_in));
    start = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick();
      repeat (NBITS) tick();
      if (n < 5) begin
        a_in = rand_volt();
        sb.push_back(ref_code(a_in));
      end else begin
        start = 1'b0;
      end
    end
    tick();
    tick();
    check("b2b_pulse_count", vcyc.size(), 6);
    for (int n = 1; n < vcyc.size(); n++)
      check($sformatf("b2b_spacing%0d", n), vcyc[n] - vcyc[n-1], NBITS + 1);

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sar_adc.md
Name: sar_adc

Overview:
- Behavioural successive-approximation ADC for the sine-wave signal chain.
- It is the inverse of the DAC model: it converts a real-valued analog input back into an NBITS-wide code, one bit per clock, MSB first.
- It lets the bench close the loop: generator code -> DAC -> sar_adc -> compare.
- Transfer function matches the DAC convention: V(code) = code * VREF / 2**NBITS.

Parameters:
- NBITS, 8: output code width / number of conversion cycles.
- VREF, 3.3: full-scale reference voltage (real).

Ports:
- clk  input  1  system clock, 100 MHz in the bench.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  conversion request, sampled on rising clk edge.
- A_in  input  real  analog input voltage.
- busy  output  1  high while a conversion is in progress.
- valid  output  1  one-cycle pulse when O_data is updated.
- O_data  output  NBITS  last completed conversion result.
- O_trial  output  NBITS  current trial code driven to the internal comparator (observability).

Behaviour:
- Interface fixed: one clock, clk; reset rst_n, asynchronous, active-low.
- Reset (asserted at any time, including mid-conversion):
  - state=IDLE; busy=0, valid=0, O_data=0, O_trial=0, held sample=0.0.
  - Any in-flight conversion is discarded, with no valid pulse.
- States: IDLE, CONV.
- IDLE:
  - On an edge with start=1: held <= A_in, bit index i <= NBITS-1, O_trial <= 1<<(NBITS-1), busy <= 1, state -> CONV.
  - Otherwise all outputs hold; valid <= 0.
- CONV, each edge resolves bit i:
  - If held >= O_trial*VREF/2**NBITS, bit i stays 1; else bit i is cleared.
  - If i>0: set bit i-1 of O_trial, i <= i-1.
  - If i==0: O_data <= resolved code, valid <= 1, busy <= 0, O_trial <= resolved code, state -> IDLE.
- Latency:
  - start sampled at edge k; valid high for exactly the cycle after edge k+NBITS.
  - busy high from edge k to edge k+NBITS (NBITS cycles).
  - Back-to-back: start high on the edge where valid rises is ignored (state is still CONV on that edge). A new conversion can begin on the next edge.
- start while busy is ignored; it is not queued.
- A_in is read only at the start edge. Later changes of A_in do not affect the running conversion.
- Result is floor(A_in*2**NBITS/VREF), saturated:
  - A_in < 0.0 -> all zeros.
  - A_in >= VREF*(2**NBITS-1)/2**NBITS -> all ones.
  - No wrap-around.
- Comparison uses >=, so an input exactly on a code threshold resolves to the upper code.
- O_data holds the previous result until the next conversion completes.

Test Plan:
1. Reset, then start pulse with A_in=1.65 -> busy high 8 cycles; valid pulses 8 edges after start; O_data=8'h80. O_trial sequence: 80,C0,A0,90,88,84,82,81, then 80.
2. A_in=1.0 -> O_data=8'h4D (77). A_in=0.0 -> 8'h00. A_in=3.3 -> 8'hFF. A_in=-0.5 -> 8'h00. A_in=5.0 -> 8'hFF.
3. Start with A_in=2.0, then switch A_in to 0.2 two cycles later -> O_data=8'h9B (155, from 2.0). Extra start pulses during busy -> no restart, exactly one valid pulse.
4. Deassert rst_n 4 cycles into a conversion -> busy, valid, O_data, O_trial all 0 immediately (asynchronous, no clock edge needed); no valid pulse. Restart with A_in=1.65 after release -> 8'h80.
5. Loopback: drive DAC I_data with codes 0..255 and feed its A_out to A_in, one conversion per code -> O_data equals I_data for every code.
6. start held high continuously -> conversions every NBITS+1 cycles; valid pulses spaced 9 cycles apart for NBITS=8.
